// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and rise-to-rise period of a PWM input
// in 1 us units. The results use the same format as the motor PWM generator's
// time_work/period inputs. The FSM state is available internally as `state`.
//
// Optional feature: define PWM_CAPTURE_FILTER_EN to add a glitch filter. The
// filtered level changes only after FILTER_LEN consecutive synchronized
// samples that disagree with the current level.
//
// Handshake: valid is a single-cycle strobe with no back-pressure. time_work
// and period change only on the cycle valid is high, or when the signal is
// declared lost, and they hold their values otherwise.

module pwm_capture #(
   parameter int CLK_DIV    = 50,
   parameter int TIMEOUT_US = 100000,
   parameter int FILTER_LEN = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pwm_in,
   output logic [23:0] time_work,
   output logic [23:0] period,
   output logic        valid,
   output logic        signal_lost
);

   localparam int          PW      = $clog2(CLK_DIV);
   localparam logic [23:0] CNT_MAX = 24'hFFFFFF;
   localparam logic [23:0] TO_VAL  = 24'(TIMEOUT_US);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t        state;
   logic          sync_q1;
   logic          sync_q2;
   logic          lvl;
   logic          lvl_d;
   logic          rise;
   logic          fall;
   logic [PW-1:0] presc;
   logic          tick;
   logic [23:0]   hi_cnt;
   logic [23:0]   per_cnt;
   logic [23:0]   idle_cnt;
   logic [23:0]   hi_next;
   logic [23:0]   per_next;
   logic          timeout;

   // Two-stage synchronizer for the asynchronous input.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= pwm_in;
         sync_q2 <= sync_q1;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN + 1);

   logic          lvl_f;
   logic [FW-1:0] flt_cnt;

   // Glitch filter: a run of FILTER_LEN disagreeing samples flips the level.
   // Any sample that agrees with the current level restarts the run.
   always_ff @(posedge clk) begin
      if (reset) begin
         lvl_f   <= 1'b0;
         flt_cnt <= '0;
      end else if (sync_q2 != lvl_f) begin
         if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            lvl_f   <= sync_q2;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + FW'(1);
         end
      end else begin
         flt_cnt <= '0;
      end
   end

   assign lvl = lvl_f;
`else
   assign lvl = sync_q2;
`endif

   // Previous-level register for edge detection.
   always_ff @(posedge clk) begin
      if (reset) lvl_d <= 1'b0;
      else       lvl_d <= lvl;
   end

   assign rise = lvl & ~lvl_d;
   assign fall = ~lvl & lvl_d;
   assign tick = (presc == PW'(CLK_DIV - 1));

   // 1 us prescaler. It is realigned on every rising edge, so each
   // measurement window starts at a tick boundary.
   always_ff @(posedge clk) begin
      if (reset)     presc <= '0;
      else if (rise) presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PW'(1);
   end

   // Saturating next-values. The period latch uses per_next so that a tick
   // landing on the edge cycle itself is counted.
   assign hi_next  = (tick && hi_cnt  != CNT_MAX) ? hi_cnt  + 24'd1 : hi_cnt;
   assign per_next = (tick && per_cnt != CNT_MAX) ? per_cnt + 24'd1 : per_cnt;

   // Inactivity counter. It stops at the limit, so it cannot wrap back below it.
   always_ff @(posedge clk) begin
      if (reset)                              idle_cnt <= '0;
      else if (rise || fall)                  idle_cnt <= '0;
      else if (tick && idle_cnt != TO_VAL)    idle_cnt <= idle_cnt + 24'd1;
   end

   // An edge in the same cycle as the timeout takes priority.
   assign timeout = (idle_cnt == TO_VAL) && !(rise || fall);

   // Measurement FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         hi_cnt      <= '0;
         per_cnt     <= '0;
         time_work   <= '0;
         period      <= '0;
         valid       <= 1'b0;
         signal_lost <= 1'b1;
      end else begin
         valid <= 1'b0;
         if (timeout) begin
            state       <= ST_IDLE;
            time_work   <= '0;
            period      <= '0;
            signal_lost <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  // The first rise opens a period. Nothing is reported yet.
                  if (rise) begin
                     state   <= ST_HIGH;
                     hi_cnt  <= '0;
                     per_cnt <= '0;
                  end
               end
               ST_HIGH: begin
                  hi_cnt  <= hi_next;
                  per_cnt <= per_next;
                  if (fall) state <= ST_LOW;
               end
               ST_LOW: begin
                  if (rise) begin
                     time_work   <= hi_cnt;
                     period      <= per_next;
                     valid       <= 1'b1;
                     signal_lost <= 1'b0;
                     hi_cnt      <= '0;
                     per_cnt     <= '0;
                     state       <= ST_HIGH;
                  end else begin
                     per_cnt <= per_next;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed test of pwm_capture with CLK_DIV = 8 and
// TIMEOUT_US = 1000, so that every phase stays short. All pulse widths are
// given in clk cycles, and the expected us values are floor(cycles / 8).

module tb_pwm_capture;

   localparam int CLK_DIV    = 8;
   localparam int TIMEOUT_US = 1000;
   localparam int FILTER_LEN = 4;

   logic        clk;
   logic        reset;
   logic        pwm_in;
   logic [23:0] time_work;
   logic [23:0] period;
   logic        valid;
   logic        signal_lost;

   int total;
   int bad;
   int valid_cnt;
   int v0;
   bit sb_en;
   logic [47:0] exp_q[$];

   pwm_capture #(
      .CLK_DIV    (CLK_DIV),
      .TIMEOUT_US (TIMEOUT_US),
      .FILTER_LEN (FILTER_LEN)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pwm_in      (pwm_in),
      .time_work   (time_work),
      .period      (period),
      .valid       (valid),
      .signal_lost (signal_lost)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Drives the input level v for n cycles. Changes happen on the falling edge.
   task automatic drive(input bit v, input int n);
      pwm_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic pwm_cycle(input int hi, input int per);
      drive(1'b1, hi);
      drive(1'b0, per - hi);
   endtask

   // One 120/1600 period with two 2-cycle low glitches. The input rises at
   // cycles 0, 42 and 82.
   task automatic glitch_period();
      drive(1'b1, 40);
      drive(1'b0, 2);
      drive(1'b1, 38);
      drive(1'b0, 2);
      drive(1'b1, 38);
      drive(1'b0, 1480);
   endtask

   task automatic push(input int tw, input int per);
      exp_q.push_back({24'(tw), 24'(per)});
   endtask

   // Scoreboard: every strobe pops one expected {time_work, period} entry.
   always @(negedge clk) begin
      if (valid) begin
         logic [47:0] e;
         valid_cnt++;
         if (sb_en) begin
            chk("lost_at_valid", 32'(signal_lost), 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("valid_time_work", 32'(time_work), 32'(e[47:24]));
               chk("valid_period",    32'(period),    32'(e[23:0]));
            end
         end
      end
   end

   initial begin
      total     = 0;
      bad       = 0;
      valid_cnt = 0;
      sb_en     = 1'b0;
      pwm_in    = 1'b0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_time_work",   32'(time_work),   32'd0);
      chk("rst_period",      32'(period),      32'd0);
      chk("rst_valid",       32'(valid),       32'd0);
      chk("rst_signal_lost", 32'(signal_lost), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      sb_en = 1'b1;

      // 15 us / 200 us. The first rise only arms the measurement.
      pwm_cycle(120, 1600);
      chk("lost_after_first_rise", 32'(signal_lost), 32'd1);
      chk("no_valid_first_rise",   32'(valid_cnt),   32'd0);
      repeat (4) push(15, 200);
      repeat (3) pwm_cycle(120, 1600);

      // Switch to 10 us / 25 us. The first strobe still reports the old period.
      repeat (2) push(10, 25);
      repeat (3) pwm_cycle(80, 200);

      // Hold low: the values hold, then a timeout clears them.
      drive(1'b0, 7000);
      chk("hold_time_work", 32'(time_work),   32'd10);
      chk("hold_period",    32'(period),      32'd25);
      chk("hold_lost",      32'(signal_lost), 32'd0);
      chk("queue_drained_1", 32'(exp_q.size()), 32'd0);
      drive(1'b0, 1200);
      chk("to_time_work", 32'(time_work),   32'd0);
      chk("to_period",    32'(period),      32'd0);
      chk("to_lost",      32'(signal_lost), 32'd1);
      chk("valid_count_before_to", 32'(valid_cnt), 32'd6);

      // Recovery: no strobe at the first rise.
      pwm_cycle(120, 1600);
      chk("recover_lost", 32'(signal_lost), 32'd1);
      chk("recover_no_valid", 32'(valid_cnt), 32'd6);
      push(15, 200);
      pwm_cycle(120, 1600);

      // Reset for one cycle during the high phase of a period.
      push(15, 200);
      drive(1'b1, 20);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_time_work", 32'(time_work),   32'd0);
      chk("midrst_period",    32'(period),      32'd0);
      chk("midrst_valid",     32'(valid),       32'd0);
      chk("midrst_lost",      32'(signal_lost), 32'd1);
      v0 = valid_cnt;
      drive(1'b1, 99);
      drive(1'b0, 1480);
      chk("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);

      // The synchronizer restarts from 0 while the input is still high, so the
      // level is seen rising 21 cycles into that period. The next rise
      // therefore reports the remaining part: 99 / 1579 cycles, which is 12 / 197.
      push(12, 197);
      push(1, 3);    // 8 / 24 cycles
      push(1, 2);    // 15 / 23 cycles: both truncated
      push(0, 3);    // 5 / 24 cycles: shorter than one tick
      pwm_cycle(8, 24);
      pwm_cycle(15, 23);
      pwm_cycle(5, 24);
      pwm_cycle(8, 24);
      drive(1'b0, 30);
      chk("queue_drained_2", 32'(exp_q.size()), 32'd0);
      chk("trunc_hold_time_work", 32'(time_work), 32'd0);
      chk("trunc_hold_period",    32'(period),    32'd3);

      // Glitch stimulus. It starts from a clean reset with the input low.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      sb_en = 1'b0;
      v0 = valid_cnt;
      glitch_period();
      glitch_period();
      pwm_cycle(120, 1600);
`ifdef PWM_CAPTURE_FILTER_EN
      chk("glitch_valid_count", 32'(valid_cnt - v0), 32'd2);
      chk("glitch_time_work",   32'(time_work),      32'd15);
      chk("glitch_period",      32'(period),         32'd200);
`else
      // Unfiltered: there are 7 rises, so 6 strobes. The last strobe measures
      // the segment from cycle 82 to 120 high and from cycle 82 to 1600 overall.
      chk("glitch_valid_count", 32'(valid_cnt - v0), 32'd6);
      chk("glitch_time_work",   32'(time_work),      32'd4);
      chk("glitch_period",      32'(period),         32'd189);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
